seq_detector_param: RTL and testbench

//  Parametrised Moore serial-pattern detector. Replaces the fixed 4-bit hard-coded FSM detectors.

---
 rtl/seq_det_pkg.sv | 33 +++
 rtl/seq_det_match.sv | 48 ++++
 rtl/seq_detector_param.sv | 121 ++++++++++++
 tb/tb_seq_detector_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector:
// overlap-mode encodings, state-width helper and pattern-length legality check.
package seq_det_pkg;

    // Overlap-mode encodings as seen on cfg_ovl / ovl_q.
    localparam logic SEQ_OVL  = 1'b1;
    localparam logic SEQ_NOVL = 1'b0;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    typedef enum logic {
        MODE_NOVL = 1'b0,
        MODE_OVL  = 1'b1
    } seq_mode_e;

    // Ceiling log2, usable in constant expressions (port and parameter widths).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit pat_w_legal(input int w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational prefix/suffix matcher. For each candidate length j (1..PAT_W)
// a comparator checks whether the newest j bits of the window equal the first
// j bits of the pattern; a priority encoder picks the longest hit.
//
// A length j is only admissible when it does not exceed cur_len+1: the bits
// older than the current matched prefix are either already known not to help
// or are not real stream bits at all (history cleared by reset or cfg_load).
// This keeps an all-zero pattern from matching the cleared history.
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int ST_W  = clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] window,       // newest bit (din) at bit 0
    input  logic [PAT_W-1:0] pat_q,        // pat_q[PAT_W-1] is the first bit expected
    input  logic [ST_W-1:0]  cur_len,
    input  logic             from_detect,
    input  logic             ovl,
    output logic [ST_W-1:0]  next_len
);

    logic [PAT_W-1:0] hit;
    logic             restart;

    // Leaving DETECT in non-overlapping mode: history is discarded, only din counts.
    assign restart = from_detect && (ovl == SEQ_NOVL);

    for (genvar j = 1; j <= PAT_W; j++) begin : g_cmp
        logic allowed;
        logic equal;

        assign allowed  = restart ? (j == 1) : ((int'(cur_len) + 1) >= j);
        assign equal    = (window[j-1:0] == pat_q[PAT_W-1 -: j]);
        assign hit[j-1] = allowed && equal;
    end

    // Priority encode: the longest admissible matching prefix wins.
    always_comb begin
        next_len = '0;
        for (int k = 0; k < PAT_W; k++) begin
            if (hit[k]) begin
                next_len = ST_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with runtime-programmable
// pattern and selectable overlapping / non-overlapping detection.
// Optional match counter enabled by defining SEQDET_CNT_EN; without it
// match_cnt is tied to zero and the port list is unchanged.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   0           | no prefix of the pattern matched (also after cfg_load)
//   k (1..W-1)  | the k most recent valid bits equal the first k pattern bits
//   PAT_W       | DETECT: full pattern seen, dout = 1
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din_vld,
    input  logic                         din,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pat,
    input  logic                         cfg_ovl,
    output logic                         dout,
    output logic [clog2(PAT_W+1)-1:0]    state,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int ST_W = clog2(PAT_W + 1);
    localparam logic [ST_W-1:0] S_IDLE   = '0;
    localparam logic [ST_W-1:0] S_DETECT = ST_W'(PAT_W);

    if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W must be within 2..16");
    end

    // The oldest of PAT_W history bits is never compared (the window already
    // holds din plus PAT_W-1 older bits), so only PAT_W-1 bits are stored.
    logic [ST_W-1:0]  state_q, state_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;

    logic [PAT_W-1:0] window;
    logic [ST_W-1:0]  next_len;

    assign window = {hist_q, din};

    seq_det_match #(
        .PAT_W (PAT_W),
        .ST_W  (ST_W)
    ) u_match (
        .window      (window),
        .pat_q       (pat_q),
        .cur_len     (state_q),
        .from_detect (state_q == S_DETECT),
        .ovl         (ovl_q),
        .next_len    (next_len)
    );

    // State, history and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            pat_q   <= '0;
            ovl_q   <= SEQ_NOVL;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
        end
    end

    // Next state: cfg_load restarts the search and wins over a valid bit.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        if (cfg_load) begin
            pat_d   = cfg_pat;
            ovl_d   = cfg_ovl;
            state_d = S_IDLE;
            hist_d  = '0;
        end else if (din_vld) begin
            state_d = next_len;
            hist_d  = window[PAT_W-2:0];
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        dout  = (state_q == S_DETECT);
        state = state_q;
    end

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             enter_detect;

    // Every valid bit that lands in DETECT is a new detection, including
    // DETECT -> DETECT in overlapping mode.
    assign enter_detect = !cfg_load && din_vld && (next_len == S_DETECT);

    // Saturating detection counter; unaffected by cfg_load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (enter_detect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 2;
    localparam int ST_W    = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQDET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din_vld = 1'b0;
    logic             din = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pat = '0;
    logic             cfg_ovl = 1'b0;
    logic             dout;
    logic [ST_W-1:0]  state;
    logic [CNT_W-1:0] match_cnt;

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_vld   (din_vld),
        .din       (din),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .cfg_ovl   (cfg_ovl),
        .dout      (dout),
        .state     (state),
        .match_cnt (match_cnt)
    );

    typedef struct {
        int st;
        bit dt;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: the real valid bits seen since the last restart,
    // and the longest pattern prefix they end with.
    bit             m_seen[$];
    int             m_state = 0;
    bit [PAT_W-1:0] m_pat = '0;
    bit             m_ovl = 1'b0;
    int             m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int longest_prefix();
        int best;
        bit ok;
        best = 0;
        for (int j = 1; j <= PAT_W && j <= m_seen.size(); j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (m_seen[m_seen.size() - j + i] != m_pat[PAT_W-1-i]) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    task automatic model_reset();
        m_seen.delete();
        m_state = 0;
        m_pat   = '0;
        m_ovl   = 1'b0;
        m_cnt   = 0;
    endtask

    // Drive one cycle of stimulus and push the expected post-edge outputs.
    task automatic step(input bit vld, input bit d, input bit load,
                        input bit [PAT_W-1:0] pat, input bit ovl);
        exp_t e;
        @(negedge clk);
        din_vld  = vld;
        din      = d;
        cfg_load = load;
        cfg_pat  = pat;
        cfg_ovl  = ovl;
        if (load) begin
            m_pat   = pat;
            m_ovl   = ovl;
            m_seen.delete();
            m_state = 0;
        end else if (vld) begin
            if (m_state == PAT_W && !m_ovl) m_seen.delete();
            m_seen.push_back(d);
            if (m_seen.size() > PAT_W) void'(m_seen.pop_front());
            m_state = longest_prefix();
            if (m_state == PAT_W && m_cnt < CNT_MAX) m_cnt++;
        end
        e.st  = m_state;
        e.dt  = (m_state == PAT_W);
        e.cnt = CNT_ON ? m_cnt : 0;
        sb_q.push_back(e);
    endtask

    task automatic load_cfg(input bit [PAT_W-1:0] pat, input bit ovl);
        step(1'b0, 1'b0, 1'b1, pat, ovl);
    endtask

    task automatic send_bits(input bit [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, m_pat, m_ovl);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, m_pat, m_ovl);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_cnt"}, 32'(match_cnt), 32'd0);
        sb_q.delete();
        model_reset();
        din_vld  = 1'b0;
        cfg_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: one expected record per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_state", 32'(state), 32'(e.st));
                check("sb_dout", 32'(dout), 32'(e.dt));
                check("sb_cnt", 32'(match_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        #2;
        check("por_state", 32'(state), 32'd0);
        check("por_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Case 1: overlapping 1011 on 1011011 -> two detects.
        load_cfg(4'b1011, 1'b1);
        send_bits(32'b1011011, 7);
        settle();
        check("c1_state", 32'(state), 32'd4);
        check("c1_cnt", 32'(match_cnt), CNT_ON ? 32'd2 : 32'd0);

        // Case 2: non-overlapping, same stream -> one detect.
        do_reset("c2rst");
        load_cfg(4'b1011, 1'b0);
        send_bits(32'b1011011, 7);
        settle();
        check("c2_state", 32'(state), 32'd1);
        check("c2_cnt", 32'(match_cnt), CNT_ON ? 32'd1 : 32'd0);

        // Case 3: 1111 overlapping on six ones -> stays in DETECT.
        do_reset("c3rst");
        load_cfg(4'b1111, 1'b1);
        send_bits(32'b111111, 6);
        settle();
        check("c3_state", 32'(state), 32'd4);
        check("c3_dout", 32'(dout), 32'd1);
        check("c3_cnt", 32'(match_cnt), CNT_ON ? 32'd3 : 32'd0);

        // Case 4: gaps of din_vld=0 between bits (with junk on din).
        do_reset("c4rst");
        load_cfg(4'b1011, 1'b1);
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, 1'((7'b1011011 >> i) & 1), 1'b0, m_pat, m_ovl);
            step(1'b0, 1'b0, 1'b0, m_pat, m_ovl);
            step(1'b0, 1'b1, 1'b0, m_pat, m_ovl);
        end
        settle();
        check("c4_dout", 32'(dout), 32'd1);
        check("c4_cnt", 32'(match_cnt), CNT_ON ? 32'd2 : 32'd0);

        // Case 5: reload at state 3, with din_vld high in the load cycle.
        do_reset("c5rst");
        load_cfg(4'b1011, 1'b1);
        send_bits(32'b101, 3);
        settle();
        check("c5_pre_state", 32'(state), 32'd3);
        step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1);
        settle();
        check("c5_load_state", 32'(state), 32'd0);
        send_bits(32'b0110, 4);
        settle();
        check("c5_dout", 32'(dout), 32'd1);

        // Case 6: saturation at 3 with five detects, then async reset at state 3.
        do_reset("c6rst");
        load_cfg(4'b1111, 1'b1);
        send_bits(32'hFF, 8);
        settle();
        check("c6_cnt", 32'(match_cnt), CNT_ON ? 32'd3 : 32'd0);
        load_cfg(4'b1111, 1'b1);
        send_bits(32'b111, 3);
        settle();
        check("c6_pre_state", 32'(state), 32'd3);
        do_reset("c6_async");

        // All-zero pattern: first zero after reset must not detect.
        load_cfg(4'b0000, 1'b0);
        send_bits(32'b0, 1);
        settle();
        check("zero_first_state", 32'(state), 32'd1);
        send_bits(32'b000, 3);
        idle();

        // Randomized phases against the reference model.
        for (int ph = 0; ph < 12; ph++) begin
            bit [PAT_W-1:0] p;
            p = PAT_W'($urandom);
            load_cfg(p, 1'($urandom));
            for (int c = 0; c < 150; c++) begin
                bit v, d, ld;
                v  = ($urandom_range(0, 3) != 0);
                d  = ($urandom_range(0, 2) != 0) ? m_pat[PAT_W-1-(c % PAT_W)] : 1'($urandom);
                ld = ($urandom_range(0, 99) == 0);
                step(v, d, ld, ld ? PAT_W'($urandom) : m_pat, ld ? 1'($urandom) : m_ovl);
            end
            if (ph % 4 == 3) do_reset("rnd_rst");
        end

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
